// File: rtl/vdot_pkg.sv
// Shared types and constants for the vdot16 dot-product unit.
package vdot_pkg;

    localparam int unsigned VDOT_LANES     = 16;
    localparam int unsigned VDOT_WIDTH     = 16;
    localparam int unsigned VDOT_FRAC_BITS = 8;
    localparam int unsigned VDOT_ACC_W     = 36;

    // Q8.8 saturation limits
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMac  = 2'b01,
        StFin  = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/vdot_sat.sv
// Combinational scale/round/saturate from the accumulator to a Q8.8 result.
// Define VDOT_ROUND_EN for round-half-up; otherwise the shift floors.
module vdot_sat
    import vdot_pkg::*;
#(
    parameter int unsigned ACC_W     = VDOT_ACC_W,
    parameter int unsigned WIDTH     = VDOT_WIDTH,
    parameter int unsigned FRAC_BITS = VDOT_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [WIDTH-1:0] value_o,
    output logic                    ovf_o
);

    logic signed [ACC_W-1:0]   biased;
    logic signed [ACC_W-1:0]   shifted;
    logic        [ACC_W-WIDTH:0] hi;

`ifdef VDOT_ROUND_EN
    localparam logic signed [ACC_W-1:0] Half = ACC_W'(1) << (FRAC_BITS - 1);
    assign biased = acc_i + Half;
`else
    assign biased = acc_i;
`endif

    assign shifted = biased >>> FRAC_BITS;
    // Result fits only if every bit from the result sign upward matches it
    assign hi = shifted[ACC_W-1:WIDTH-1];

    always_comb begin
        ovf_o   = (hi != '0) && (hi != '1);
        value_o = shifted[WIDTH-1:0];
        if (ovf_o) begin
            value_o = shifted[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/vdot16.sv
// Sequential 16-lane signed dot product: one MAC per clock, then Q8.8 saturate.
// Rounding mode is selected by the VDOT_ROUND_EN macro inside vdot_sat.
module vdot16
    import vdot_pkg::*;
#(
    parameter int unsigned LANES     = VDOT_LANES,
    parameter int unsigned WIDTH     = VDOT_WIDTH,
    parameter int unsigned ACC_W     = VDOT_ACC_W,
    parameter int unsigned FRAC_BITS = VDOT_FRAC_BITS
) (
    input  logic                   Clk1,
    input  logic                   Reset,
    input  logic                   start,
    input  logic [LANES*WIDTH-1:0] Inval1,
    input  logic [LANES*WIDTH-1:0] Inval2,
    output logic [WIDTH-1:0]       DotOut,
    output logic                   Overflw,
    output logic                   done,
    output logic                   busy
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e                   state_q, state_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LANES*WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]         dot_q, dot_d;
    logic                     ovf_q, ovf_d;
    logic                     done_q, done_d;

    logic signed [WIDTH-1:0]   a_lane, b_lane;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [WIDTH-1:0]          sat_value;
    logic                      sat_ovf;

    assign a_lane   = a_q[int'(lane_q)*WIDTH +: WIDTH];
    assign b_lane   = b_q[int'(lane_q)*WIDTH +: WIDTH];
    assign prod     = a_lane * b_lane;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    vdot_sat #(
        .ACC_W    (ACC_W),
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) u_sat (
        .acc_i  (acc_q),
        .value_o(sat_value),
        .ovf_o  (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        dot_d   = dot_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = Inval1;
                    b_d     = Inval2;
                    acc_d   = '0;
                    lane_d  = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d  = acc_q + prod_ext;
                lane_d = lane_q + LW'(1);
                if (lane_q == LW'(LANES - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                dot_d   = sat_value;
                ovf_d   = sat_ovf;
                state_d = StDone;
            end
            StDone: begin
                // First DONE cycle raises done; it then holds until start is seen low
                done_d = start || !done_q;
                if (done_q && !start) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            lane_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dot_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dot_q   <= dot_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign DotOut  = dot_q;
    assign Overflw = ovf_q;
    assign done    = done_q;
    assign busy    = (state_q == StMac) || (state_q == StFin);

endmodule
